// File: rtl/banco_pkg.sv
// Shared types and defaults for the register bank.
// Reused by decode and hazard units.
package banco_pkg;
  localparam int DW_DEF    = 32;
  localparam int NREG_DEF  = 32;
  localparam int ZERO_ADDR = 0;

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;
  typedef logic [DW_DEF-1:0]           reg_data_t;
endpackage

// File: rtl/banco_rdport.sv
// One read port: bank mux output with write-through
// bypass and zero-register masking.
module banco_rdport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0] ra,
  input  logic [DW-1:0] rd_data,
  input  logic          busy_in,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] dr,
  output logic          busy
);
  logic hit;
  logic zero;

  // Forward in-flight write; register 0 always masks
  always_comb begin
    hit  = BYPASS && we && (wa == ra);
    zero = ZERO_REG && (ra == '0);
    dr   = rd_data;
    busy = busy_in;
    if (zero) begin
      dr   = '0;
      busy = 1'b0;
    end else if (hit) begin
      dr   = wd;
      busy = 1'b0;
    end
  end
endmodule

// File: rtl/banco_param.sv
// Parametrised register bank with bypass, zero
// register and a busy scoreboard for hazards.
module banco_param
  import banco_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int AW       = $clog2(NREG),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RegEn,
  input  logic [AW-1:0] aw,
  input  logic [DW-1:0] dataIn_b,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] dr1,
  output logic [DW-1:0] dr2,
  input  logic          ResEn,
  input  logic [AW-1:0] ResA,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt
);
  localparam int CW = AW + 1;

  logic [DW-1:0]   bank_q [NREG];
  logic [DW-1:0]   bank_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            we_ok;
  logic            res_ok;
  logic            inc;
  logic            dec;

  // Next state: write clears busy, reserve wins
  always_comb begin
    bank_d = bank_q;
    busy_d = busy_q;
    we_ok  = RegEn &&
             !(ZERO_REG && aw == AW'(ZERO_ADDR));
    res_ok = ResEn &&
             !(ZERO_REG && ResA == AW'(ZERO_ADDR));
    inc    = res_ok && !busy_q[ResA];
    dec    = we_ok && busy_q[aw] &&
             !(res_ok && ResA == aw);
    if (we_ok) begin
      bank_d[aw] = dataIn_b;
      busy_d[aw] = 1'b0;
    end
    if (res_ok) begin
      busy_d[ResA] = 1'b1;
    end
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  // State registers, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        bank_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      bank_q <= bank_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  banco_rdport #(
    .DW(DW), .AW(AW),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd1 (
    .ra      (ra1),
    .rd_data (bank_q[ra1]),
    .busy_in (busy_q[ra1]),
    .we      (RegEn),
    .wa      (aw),
    .wd      (dataIn_b),
    .dr      (dr1),
    .busy    (busy1)
  );

  banco_rdport #(
    .DW(DW), .AW(AW),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rd2 (
    .ra      (ra2),
    .rd_data (bank_q[ra2]),
    .busy_in (busy_q[ra2]),
    .we      (RegEn),
    .wa      (aw),
    .wd      (dataIn_b),
    .dr      (dr2),
    .busy    (busy2)
  );
endmodule

// File: tb/tb_banco_param.sv
// Directed bench for banco_param, with a
// bypass and a no-bypass instance side by side.
module tb_banco_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegEn;
  logic [4:0]  aw;
  logic [31:0] dataIn_b;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        ResEn;
  logic [4:0]  ResA;

  logic [31:0] dr1_b, dr2_b, dr1_n, dr2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banco_param #(.BYPASS(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .RegEn(RegEn),
    .aw(aw), .dataIn_b(dataIn_b),
    .ra1(ra1), .ra2(ra2),
    .dr1(dr1_b), .dr2(dr2_b),
    .ResEn(ResEn), .ResA(ResA),
    .busy1(busy1_b), .busy2(busy2_b),
    .busy_cnt(cnt_b)
  );

  banco_param #(.BYPASS(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .RegEn(RegEn),
    .aw(aw), .dataIn_b(dataIn_b),
    .ra1(ra1), .ra2(ra2),
    .dr1(dr1_n), .dr2(dr2_n),
    .ResEn(ResEn), .ResA(ResA),
    .busy1(busy1_n), .busy2(busy2_n),
    .busy_cnt(cnt_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegEn = 1'b0;
    ResEn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    aw = '0; dataIn_b = '0;
    ra1 = '0; ra2 = '0; ResA = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Preload r5 and reserve r3, then async reset
    RegEn = 1'b1; aw = 5'd5;
    dataIn_b = 32'hDEADBEEF;
    ResEn = 1'b1; ResA = 5'd3;
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd3;
    #1;
    chk("pre_rst_dr1", dr1_b, 32'hDEADBEEF);
    chk("pre_rst_busy2", 32'(busy2_b), 32'd1);
    chk("pre_rst_cnt", 32'(cnt_b), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_dr1", dr1_b, 32'h0);
    chk("rst_dr2", dr2_b, 32'h0);
    chk("rst_busy1", 32'(busy1_b), 32'd0);
    chk("rst_busy2", 32'(busy2_b), 32'd0);
    chk("rst_cnt", 32'(cnt_b), 32'd0);
    rst_n = 1'b1;

    // Write r5, read back on both ports
    RegEn = 1'b1; aw = 5'd5;
    dataIn_b = 32'h12345678;
    tick();
    idle();
    ra1 = 5'd5; ra2 = 5'd6;
    #1;
    chk("wr_dr1", dr1_b, 32'h12345678);
    chk("wr_dr2", dr2_b, 32'h0);

    // Same-cycle bypass vs none
    RegEn = 1'b1; aw = 5'd7;
    dataIn_b = 32'hA5A5A5A5;
    ra1 = 5'd7;
    #1;
    chk("byp_dr1", dr1_b, 32'hA5A5A5A5);
    chk("nobyp_dr1", dr1_n, 32'h0);
    tick();
    idle();
    #1;
    chk("nobyp_after", dr1_n, 32'hA5A5A5A5);

    // Zero register ignores write and reserve
    RegEn = 1'b1; aw = 5'd0;
    dataIn_b = 32'hFFFFFFFF;
    ResEn = 1'b1; ResA = 5'd0;
    ra1 = 5'd0;
    #1;
    chk("zero_byp_dr1", dr1_b, 32'h0);
    chk("zero_byp_busy", 32'(busy1_b), 32'd0);
    tick();
    idle();
    #1;
    chk("zero_dr1", dr1_b, 32'h0);
    chk("zero_busy1", 32'(busy1_b), 32'd0);
    chk("zero_cnt", 32'(cnt_b), 32'd0);

    // Reserve r3 then r4
    ResEn = 1'b1; ResA = 5'd3;
    tick();
    ResA = 5'd4;
    tick();
    idle();
    ra1 = 5'd3;
    #1;
    chk("res_cnt2", 32'(cnt_b), 32'd2);
    chk("res_busy1", 32'(busy1_b), 32'd1);

    // Write r3: bypass hides busy early
    RegEn = 1'b1; aw = 5'd3;
    dataIn_b = 32'h33;
    #1;
    chk("wr3_byp_busy", 32'(busy1_b), 32'd0);
    chk("wr3_byp_dr", dr1_b, 32'h33);
    chk("wr3_nobyp_busy", 32'(busy1_n), 32'd1);
    tick();
    idle();
    #1;
    chk("wr3_busy1", 32'(busy1_b), 32'd0);
    chk("wr3_cnt", 32'(cnt_b), 32'd1);

    // Write to idle r9 leaves count alone
    RegEn = 1'b1; aw = 5'd9;
    dataIn_b = 32'h99;
    tick();
    idle();
    #1;
    chk("wr9_cnt", 32'(cnt_b), 32'd1);

    // Write+reserve r4 while busy
    RegEn = 1'b1; aw = 5'd4;
    dataIn_b = 32'h44;
    ResEn = 1'b1; ResA = 5'd4;
    tick();
    idle();
    ra1 = 5'd4;
    #1;
    chk("sim_busy_dr", dr1_b, 32'h44);
    chk("sim_busy_b1", 32'(busy1_b), 32'd1);
    chk("sim_busy_cnt", 32'(cnt_b), 32'd1);

    // Clear r4 while reserving r6: net 0
    RegEn = 1'b1; aw = 5'd4;
    dataIn_b = 32'h40;
    ResEn = 1'b1; ResA = 5'd6;
    tick();
    idle();
    ra2 = 5'd6;
    #1;
    chk("mix_busy1", 32'(busy1_b), 32'd0);
    chk("mix_busy2", 32'(busy2_b), 32'd1);
    chk("mix_cnt", 32'(cnt_b), 32'd1);

    // Write+reserve r4 while idle: +1
    RegEn = 1'b1; aw = 5'd4;
    dataIn_b = 32'h55;
    ResEn = 1'b1; ResA = 5'd4;
    tick();
    idle();
    #1;
    chk("sim_idle_dr", dr1_b, 32'h55);
    chk("sim_idle_b1", 32'(busy1_b), 32'd1);
    chk("sim_idle_cnt", 32'(cnt_b), 32'd2);
    chk("nb_cnt", 32'(cnt_n), 32'd2);

    // Reset held across an edge drops the write
    RegEn = 1'b1; aw = 5'd8;
    dataIn_b = 32'h88;
    rst_n = 1'b0;
    tick();
    idle();
    rst_n = 1'b1;
    ra1 = 5'd8;
    #1;
    chk("rst_wr_dr1", dr1_b, 32'h0);
    chk("rst_wr_cnt", 32'(cnt_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
